// File: rtl/barcode_pkg.sv
// -----------------------------------------------------------------------------
// barcode_pkg
// Shared definitions for the barcode entry buffer: default geometry, the code
// used for an empty digit slot, the 10 s idle timeout at 50 MHz, the entry
// FSM state encoding and the per-cycle action chosen by the strobe arbiter.
// -----------------------------------------------------------------------------
package barcode_pkg;

  localparam int         NUM_DIGITS_DEFAULT = 4;
  localparam int         DIGIT_W_DEFAULT    = 4;
  localparam logic [3:0] BLANK_DIGIT        = 4'hF;
  localparam int         TIMEOUT_10S_50MHZ  = 500_000_000;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL,
    PRESENT
  } state_e;

  // The single action taken on a clock edge after strobe arbitration.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_BACK,
    ACT_DIGIT,
    ACT_COMMIT,
    ACT_TIMEOUT
  } action_e;

endpackage

// File: rtl/barcode_entry_buffer_if.sv
// -----------------------------------------------------------------------------
// barcode_entry_buffer_if
// Keypad-side strobes plus the downstream valid/ready barcode handshake.
//   master : drives ENABLE, Digit_in, BACKSPACE, CLEAR, COMMIT, BARCODE_READY
//   slave  : drives BARCODE_VALID, Barcode_Digits, Digit_Count,
//            BarcodeDigitCompleted, TIMEOUT
// -----------------------------------------------------------------------------
interface barcode_entry_buffer_if
  import barcode_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int DIGIT_W    = DIGIT_W_DEFAULT
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                          ENABLE;
  logic [DIGIT_W-1:0]            Digit_in;
  logic                          BACKSPACE;
  logic                          CLEAR;
  logic                          COMMIT;
  logic                          BARCODE_READY;
  logic                          BARCODE_VALID;
  logic [NUM_DIGITS*DIGIT_W-1:0] Barcode_Digits;
  logic [CNT_W-1:0]              Digit_Count;
  logic                          BarcodeDigitCompleted;
  logic                          TIMEOUT;

  modport master (
    output ENABLE, Digit_in, BACKSPACE, CLEAR, COMMIT, BARCODE_READY,
    input  BARCODE_VALID, Barcode_Digits, Digit_Count, BarcodeDigitCompleted,
           TIMEOUT
  );

  modport slave (
    input  ENABLE, Digit_in, BACKSPACE, CLEAR, COMMIT, BARCODE_READY,
    output BARCODE_VALID, Barcode_Digits, Digit_Count, BarcodeDigitCompleted,
           TIMEOUT
  );

endinterface

// File: rtl/barcode_idle_timer.sv
// -----------------------------------------------------------------------------
// barcode_idle_timer
// Counts clock cycles while 'run' is high. 'restart' (or run low) returns the
// count to 0. 'expire' is high during the cycle in which the count sits at
// TIMEOUT_CYCLES-1 while running, i.e. TIMEOUT_CYCLES edges after a restart.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : force the count back to 0 on the next edge
//   run        : count enable
//   expire     : idle period elapsed
// -----------------------------------------------------------------------------
module barcode_idle_timer
  import barcode_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_10S_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic expire
);

  localparam int                CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !run || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/barcode_entry_buffer.sv
// -----------------------------------------------------------------------------
// barcode_entry_buffer
// Collects decimal digits from a keypad into a NUM_DIGITS-wide shift buffer
// (digit 0 newest), supports backspace/clear, and presents a complete barcode
// downstream with a valid/ready handshake. A partial entry left idle for
// TIMEOUT_CYCLES is discarded with a one-cycle TIMEOUT pulse.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus (slave)  : strobes in; barcode, count, flags out (all registered)
// -----------------------------------------------------------------------------
module barcode_entry_buffer
  import barcode_pkg::*;
#(
  parameter int                 NUM_DIGITS     = NUM_DIGITS_DEFAULT,
  parameter int                 DIGIT_W        = DIGIT_W_DEFAULT,
  parameter logic [DIGIT_W-1:0] BLANK          = DIGIT_W'(BLANK_DIGIT),
  parameter int                 TIMEOUT_CYCLES = TIMEOUT_10S_50MHZ
) (
  input logic                   CLK,
  input logic                   RESET_N,
  barcode_entry_buffer_if.slave bus
);

  localparam int               TOTAL_W    = NUM_DIGITS * DIGIT_W;
  localparam int               CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_DIGITS);
  localparam logic [TOTAL_W-1:0] ALL_BLANK = {NUM_DIGITS{BLANK}};

  state_e             state_q, state_d;
  logic [TOTAL_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  action_e            action;
  logic               entry_active;
  logic               digit_ok;
  logic               expire;
  logic               timer_restart;

  assign entry_active = (state_q == ENTRY) || (state_q == FULL);
  assign digit_ok     = (bus.Digit_in <= DIGIT_W'(9));

  // Strobe arbitration: the highest-priority strobe present decides the
  // action; if it is not meaningful in the current state, the lower strobes
  // are still dropped. The idle timeout only fires when no strobe acted.
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    action = ACT_NONE;
    if (state_q != PRESENT) begin
      if (bus.CLEAR) begin
        if (entry_active) action = ACT_CLEAR;
      end else if (bus.BACKSPACE) begin
        if (entry_active) action = ACT_BACK;
      end else if (bus.ENABLE) begin
        if (digit_ok && state_q != FULL) action = ACT_DIGIT;
      end else if (bus.COMMIT) begin
        if (state_q == FULL) action = ACT_COMMIT;
      end
    end
    if (action == ACT_NONE && expire) action = ACT_TIMEOUT;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    count_d   = count_q;
    timeout_d = 1'b0;

    unique case (action)
      ACT_CLEAR, ACT_TIMEOUT: begin
        state_d   = EMPTY;
        digits_d  = ALL_BLANK;
        count_d   = '0;
        timeout_d = (action == ACT_TIMEOUT);
      end
      ACT_BACK: begin
        digits_d = {BLANK, digits_q[TOTAL_W-1:DIGIT_W]};
        count_d  = count_q - CNT_W'(1);
        state_d  = (count_d == '0) ? EMPTY : ENTRY;
      end
      ACT_DIGIT: begin
        digits_d = {digits_q[TOTAL_W-DIGIT_W-1:0], bus.Digit_in};
        count_d  = count_q + CNT_W'(1);
        state_d  = (count_d == FULL_COUNT) ? FULL : ENTRY;
      end
      ACT_COMMIT: begin
        state_d = PRESENT;
      end
      default: begin
        // Downstream accepts the presented barcode.
        if (state_q == PRESENT && valid_q && bus.BARCODE_READY) begin
          state_d  = EMPTY;
          digits_d = ALL_BLANK;
          count_d  = '0;
        end
      end
    endcase

    valid_d = (state_d == PRESENT);
    done_d  = (count_d == FULL_COUNT);
  end

  // NOTE: the digit buffer is reset like any other register because its
  // contents are directly visible on Barcode_Digits; blank slots must read as
  // BLANK from the moment reset asserts.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= EMPTY;
      digits_q  <= ALL_BLANK;
      count_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // The timer restarts on every accepted digit/backspace and is also zeroed
  // on any edge that leaves ENTRY/FULL, so it sits at 0 in EMPTY and PRESENT.
  assign timer_restart = (action == ACT_BACK) || (action == ACT_DIGIT) ||
                         !((state_d == ENTRY) || (state_d == FULL));

  barcode_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .restart(timer_restart),
    .run    (entry_active),
    .expire (expire)
  );

  assign bus.BARCODE_VALID         = valid_q;
  assign bus.Barcode_Digits        = digits_q;
  assign bus.Digit_Count           = count_q;
  assign bus.BarcodeDigitCompleted = done_q;
  assign bus.TIMEOUT               = timeout_q;

endmodule

// File: tb/tb_barcode_entry_buffer.sv
// -----------------------------------------------------------------------------
// tb_barcode_entry_buffer
// Directed vector table, hand-written timeout/reset sequences, then random
// stimulus against a queue-based reference model of the entry buffer.
// -----------------------------------------------------------------------------
module tb_barcode_entry_buffer;
  import barcode_pkg::*;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 16;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  barcode_entry_buffer_if #(.NUM_DIGITS(N), .DIGIT_W(W)) bus ();

  barcode_entry_buffer #(
    .NUM_DIGITS    (N),
    .DIGIT_W       (W),
    .BLANK         (4'hF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic [3:0]  d;
    logic        bs;
    logic        clr;
    logic        cmt;
    logic        rdy;
    logic [15:0] x_dig;
    int          x_cnt;
    logic        x_val;
    logic        x_done;
    logic        x_to;
  } vec_t;

  vec_t vecs[$];

  // ---------------- reference model: digits as a queue, newest first -------
  logic [3:0] m_q[$];
  bit         m_present;
  int         m_idle;
  bit         m_to;

  task automatic model_reset();
    m_q.delete();
    m_present = 0;
    m_idle    = 0;
    m_to      = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] d, input logic bs,
                            input logic clr, input logic cmt, input logic rdy);
    bit acted   = 0;
    bit restart = 0;
    m_to = 0;
    if (m_present) begin
      if (rdy) begin
        m_present = 0;
        m_q.delete();
      end
    end else begin
      if (clr) begin
        if (m_q.size() > 0) begin m_q.delete(); acted = 1; end
      end else if (bs) begin
        if (m_q.size() > 0) begin void'(m_q.pop_front()); acted = 1; restart = 1; end
      end else if (en) begin
        if (d <= 9 && m_q.size() < N) begin m_q.push_front(d); acted = 1; restart = 1; end
      end else if (cmt) begin
        if (m_q.size() == N) begin m_present = 1; acted = 1; end
      end
      // An untouched pending entry that has sat idle TO cycles is dropped.
      if (!acted && m_q.size() > 0 && m_idle == TO - 1) begin
        m_q.delete();
        m_to = 1;
      end
    end
    if (restart || m_present || m_q.size() == 0) m_idle = 0;
    else m_idle++;
  endtask

  function automatic logic [15:0] m_digits();
    logic [15:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = (i < m_q.size()) ? m_q[i] : 4'hF;
    return r;
  endfunction

  // ---------------- helpers ------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] dig, input int cnt,
                           input logic val, input logic done, input logic to);
    check({tag, ".digits"}, 32'(bus.Barcode_Digits), 32'(dig));
    check({tag, ".count"},  32'(bus.Digit_Count), 32'(cnt));
    check({tag, ".valid"},  32'(bus.BARCODE_VALID), 32'(val));
    check({tag, ".done"},   32'(bus.BarcodeDigitCompleted), 32'(done));
    check({tag, ".timeout"}, 32'(bus.TIMEOUT), 32'(to));
  endtask

  task automatic drive(input logic en, input logic [3:0] d, input logic bs,
                       input logic clr, input logic cmt, input logic rdy);
    bus.ENABLE        = en;
    bus.Digit_in      = d;
    bus.BACKSPACE     = bs;
    bus.CLEAR         = clr;
    bus.COMMIT        = cmt;
    bus.BARCODE_READY = rdy;
  endtask

  task automatic idle();
    drive(0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic v(input logic en, input logic [3:0] d, input logic bs, input logic clr,
                   input logic cmt, input logic rdy, input logic [15:0] x_dig,
                   input int x_cnt, input logic x_val, input logic x_done);
    vec_t t;
    t.en = en; t.d = d; t.bs = bs; t.clr = clr; t.cmt = cmt; t.rdy = rdy;
    t.x_dig = x_dig; t.x_cnt = x_cnt; t.x_val = x_val; t.x_done = x_done; t.x_to = 1'b0;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    idle();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
  endtask

  // ---------------- random stimulus state ----------------------------------
  logic       r_en, r_bs, r_clr, r_cmt, r_rdy;
  logic [3:0] r_d;
  int         quiet;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    do_reset();
    check_out("reset", 16'hFFFF, 0, 0, 0, 0);

    //  en  d    bs clr cmt rdy   digits   cnt val done
    // Fill 1,2,3,4 and present; READY low holds the barcode for 10 cycles,
    // during which CLEAR/COMMIT/ENABLE/BACKSPACE are ignored.
    v(1, 4'd1, 0, 0, 0, 0, 16'hFFF1, 1, 0, 0);
    v(1, 4'd2, 0, 0, 0, 0, 16'hFF12, 2, 0, 0);
    v(1, 4'd3, 0, 0, 0, 0, 16'hF123, 3, 0, 0);
    v(1, 4'd4, 0, 0, 0, 0, 16'h1234, 4, 0, 1);
    v(0, 4'd0, 0, 0, 1, 0, 16'h1234, 4, 1, 1);
    v(0, 4'd0, 0, 1, 0, 0, 16'h1234, 4, 1, 1);
    v(0, 4'd0, 0, 0, 1, 0, 16'h1234, 4, 1, 1);
    v(1, 4'd5, 0, 0, 0, 0, 16'h1234, 4, 1, 1);
    v(0, 4'd0, 1, 0, 0, 0, 16'h1234, 4, 1, 1);
    for (int i = 0; i < 6; i++) v(0, 4'd0, 0, 0, 0, 0, 16'h1234, 4, 1, 1);
    v(0, 4'd0, 0, 0, 0, 1, 16'hFFFF, 0, 0, 0);
    // Backspace down to empty, then a backspace on empty.
    v(1, 4'd7, 0, 0, 0, 0, 16'hFFF7, 1, 0, 0);
    v(1, 4'd8, 0, 0, 0, 0, 16'hFF78, 2, 0, 0);
    v(0, 4'd0, 1, 0, 0, 0, 16'hFFF7, 1, 0, 0);
    v(0, 4'd0, 1, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    v(0, 4'd0, 1, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    // Non-decimal digit, ENABLE+BACKSPACE, digit while FULL, CLEAR beats COMMIT.
    v(1, 4'hA, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    v(1, 4'd3, 0, 0, 0, 0, 16'hFFF3, 1, 0, 0);
    v(1, 4'd6, 0, 0, 0, 0, 16'hFF36, 2, 0, 0);
    v(1, 4'd9, 1, 0, 0, 0, 16'hFFF3, 1, 0, 0);
    v(1, 4'd0, 0, 0, 0, 0, 16'hFF30, 2, 0, 0);
    v(1, 4'd1, 0, 0, 0, 0, 16'hF301, 3, 0, 0);
    v(1, 4'd2, 0, 0, 0, 0, 16'h3012, 4, 0, 1);
    v(1, 4'd5, 0, 0, 0, 0, 16'h3012, 4, 0, 1);
    v(0, 4'd0, 0, 1, 1, 0, 16'hFFFF, 0, 0, 0);
    // COMMIT on a partial entry is ignored; CLEAR on ENTRY empties it.
    v(1, 4'd1, 0, 0, 0, 0, 16'hFFF1, 1, 0, 0);
    v(0, 4'd0, 0, 0, 1, 1, 16'hFFF1, 1, 0, 0);
    v(0, 4'd0, 0, 1, 0, 0, 16'hFFFF, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].d, vecs[i].bs, vecs[i].clr, vecs[i].cmt, vecs[i].rdy);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].x_dig, vecs[i].x_cnt,
                vecs[i].x_val, vecs[i].x_done, vecs[i].x_to);
    end

    // Idle timeout: fires exactly TO edges after the last digit, once.
    drive(1, 4'd5, 0, 0, 0, 0);
    tick();
    check_out("to_digit", 16'hFFF5, 1, 0, 0, 0);
    idle();
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) check_out($sformatf("to_wait%0d", k), 16'hFFF5, 1, 0, 0, 0);
      else        check_out("to_fire", 16'hFFFF, 0, 0, 0, 1);
    end
    tick();
    check_out("to_after", 16'hFFFF, 0, 0, 0, 0);

    // A digit on cycle 15 restarts the idle count: no timeout follows.
    drive(1, 4'd5, 0, 0, 0, 0);
    tick();
    idle();
    repeat (TO - 2) tick();
    drive(1, 4'd6, 0, 0, 0, 0);
    tick();
    check_out("rs_digit", 16'hFF56, 2, 0, 0, 0);
    idle();
    for (int k = 1; k < TO; k++) begin
      tick();
      check_out($sformatf("rs_wait%0d", k), 16'hFF56, 2, 0, 0, 0);
    end
    drive(0, 4'd0, 0, 1, 0, 0);
    tick();
    check_out("rs_clear", 16'hFFFF, 0, 0, 0, 0);

    // Asynchronous reset mid-entry, between clock edges.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 4'(i), 0, 0, 0, 0);
      tick();
    end
    check_out("ar_pre", 16'hF123, 3, 0, 0, 0);
    idle();
    #2 RESET_N = 1'b0;
    #1 check_out("ar_mid", 16'hFFFF, 0, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Asynchronous reset while presenting.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'(i), 0, 0, 0, 0);
      tick();
    end
    drive(0, 4'd0, 0, 0, 1, 0);
    tick();
    check_out("ar_present", 16'h1234, 4, 1, 1, 0);
    idle();
    #2 RESET_N = 1'b0;
    #1 check_out("ar_in_present", 16'hFFFF, 0, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    // First digit after release lands on the first edge.
    drive(1, 4'd7, 0, 0, 0, 0);
    tick();
    check_out("ar_first", 16'hFFF7, 1, 0, 0, 0);

    // Random stimulus against the reference model.
    do_reset();
    model_reset();
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet == 0 && $urandom_range(0, 39) == 0) quiet = $urandom_range(10, 20);
      if (quiet > 0) begin
        quiet--;
        r_en = 0; r_d = 4'd0; r_bs = 0; r_clr = 0; r_cmt = 0; r_rdy = 0;
      end else begin
        r_en  = ($urandom_range(0, 99) < 40);
        r_d   = 4'($urandom_range(0, 11));
        r_bs  = ($urandom_range(0, 99) < 8);
        r_clr = ($urandom_range(0, 99) < 3);
        r_cmt = ($urandom_range(0, 99) < 15);
        r_rdy = ($urandom_range(0, 99) < 30);
      end
      drive(r_en, r_d, r_bs, r_clr, r_cmt, r_rdy);
      model_step(r_en, r_d, r_bs, r_clr, r_cmt, r_rdy);
      tick();
      check_out($sformatf("rnd%0d", c), m_digits(), m_q.size(), m_present,
                (m_q.size() == N), m_to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barcode_entry_buffer.md
BARCODE_ENTRY_BUFFER -- requirements
Module: barcode_entry_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 4: barcode length in digits, range 2..8.
REQ-002 Parameter DIGIT_W, default 4: bits per digit.
REQ-003 Parameter BLANK, default 4'hF: code marking an empty digit slot.
REQ-004 Parameter TIMEOUT_CYCLES, default 500_000_000: idle cycles before a partial entry is discarded (10 s at 50 MHz).
REQ-005 CLK  in  1  single clock, rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 ENABLE  in  1  one-cycle digit strobe; qualifies Digit_in.
REQ-008 Digit_in  in  DIGIT_W  digit value, sampled when ENABLE=1.
REQ-009 BACKSPACE  in  1  one-cycle strobe: remove the newest digit.
REQ-010 CLEAR  in  1  one-cycle strobe: discard the entry.
REQ-011 COMMIT  in  1  one-cycle strobe: present a complete barcode downstream.
REQ-012 BARCODE_READY  in  1  downstream accepts the presented barcode.
REQ-013 BARCODE_VALID  out  1  barcode presented, stable until accepted.
REQ-014 Barcode_Digits  out  NUM_DIGITS*DIGIT_W  digit i at bits [i*DIGIT_W +: DIGIT_W]; digit 0 is the newest.
REQ-015 Digit_Count  out  $clog2(NUM_DIGITS+1)  number of digits held.
REQ-016 BarcodeDigitCompleted  out  1  high when Digit_Count==NUM_DIGITS.
REQ-017 TIMEOUT  out  1  one-cycle pulse when a partial entry is discarded by timeout.

Function
REQ-018 The FSM SHALL have the states EMPTY, ENTRY, FULL and PRESENT; all outputs SHALL be registered.
REQ-019 A digit SHALL be accepted only when ENABLE=1, Digit_in<=9 and state is EMPTY or ENTRY; Digit_in>9 SHALL be ignored with no state change.
REQ-020 An accepted digit SHALL shift digit i to i+1, load Digit_in into digit 0 and increment Digit_Count; outputs SHALL update on the next edge (1-cycle latency).
REQ-021 The state SHALL go EMPTY->ENTRY on the first digit and ENTRY->FULL when Digit_Count reaches NUM_DIGITS.
REQ-022 BACKSPACE in ENTRY or FULL SHALL shift digit i+1 to i, load BLANK into digit NUM_DIGITS-1 and decrement the count; the state SHALL return to ENTRY, or to EMPTY when the count reaches 0.
REQ-023 BACKSPACE in EMPTY SHALL be ignored.
REQ-024 CLEAR in ENTRY or FULL SHALL set all digits to BLANK, the count to 0 and the state to EMPTY.
REQ-025 Same-cycle strobes SHALL follow the priority CLEAR > BACKSPACE > ENABLE > COMMIT; the lower-priority strobes SHALL be dropped.
REQ-026 COMMIT in FULL SHALL enter PRESENT and assert BARCODE_VALID; COMMIT in any other state SHALL be ignored.
REQ-027 In PRESENT, digits, count and BARCODE_VALID SHALL hold; ENABLE, BACKSPACE, CLEAR and COMMIT SHALL be ignored.
REQ-028 BARCODE_VALID & BARCODE_READY SHALL complete the transfer: on the next edge VALID=0, all digits BLANK, count 0, state EMPTY.
REQ-029 The idle counter SHALL run only in ENTRY/FULL and SHALL restart at 0 on every accepted ENABLE or BACKSPACE.
REQ-030 On reaching TIMEOUT_CYCLES-1 the idle counter SHALL perform the CLEAR action and pulse TIMEOUT for one cycle; a same-cycle accepted strobe SHALL take precedence over the timeout.
REQ-031 The idle counter SHALL hold at 0 in EMPTY and PRESENT.

Reset
REQ-032 RESET_N=0 SHALL asynchronously force state EMPTY, all digits BLANK, count 0, idle counter 0, and BARCODE_VALID, BarcodeDigitCompleted and TIMEOUT all 0, including mid-entry and in PRESENT.
REQ-033 The first digit after reset release SHALL be accepted on the first qualifying edge.

Structure
REQ-034 A shared package barcode_pkg SHALL hold the state enum, DIGIT_W_DEFAULT, BLANK_DIGIT and a TIMEOUT_10S_50MHZ constant.
REQ-035 The idle timer SHALL be a sub-module barcode_idle_timer (inputs restart and run; output expire) parametrised by TIMEOUT_CYCLES.
REQ-036 7-segment decoding SHALL stay outside this block.

Verification (NUM_DIGITS=4, TIMEOUT_CYCLES=16)
REQ-037 Digits 1,2,3,4, then COMMIT, with BARCODE_READY held 0 -> Barcode_Digits=16'h1234, FULL->PRESENT, VALID held high for 10 cycles; READY=1 -> next cycle VALID=0 and digits 16'hFFFF.
REQ-038 Digits 7,8 then BACKSPACE -> 16'hFFF7, count 1; BACKSPACE again -> EMPTY; a third BACKSPACE -> no change.
REQ-039 Digit_in=4'hA with ENABLE -> ignored; ENABLE+BACKSPACE in one cycle at count 2 -> count 1, digit dropped; fifth digit while FULL -> ignored.
REQ-040 Digit 5 then 16 idle cycles -> TIMEOUT pulses once, count 0; a digit on cycle 15 restarts the count and no TIMEOUT occurs.
REQ-041 RESET_N low mid-entry (count 3) and in PRESENT -> immediate EMPTY, VALID=0 without waiting for a clock edge.
REQ-042 CLEAR and COMMIT while in PRESENT -> ignored, digits unchanged.
